// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: FSM encoding, prefix bytes,
// direction scan codes and the direction lookup helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  localparam logic [7:0] PFX_E0   = 8'hE0;
  localparam logic [7:0] PFX_E1   = 8'hE1;
  localparam logic [7:0] PFX_F0   = 8'hF0;
  localparam logic [7:0] CODE_FA  = 8'hFA;
  localparam logic [7:0] CODE_AA  = 8'hAA;
  localparam logic [7:0] CODE_OV0 = 8'h00;
  localparam logic [7:0] CODE_OVF = 8'hFF;

  // Arrow keys only count when E0-prefixed; WASD only when not.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Direction mask, bit order {right, left, down, up}.
  function automatic logic [3:0] dir_of(input logic [7:0] code, input logic ext);
    dir_of = 4'b0000;
    if (ext) begin
      case (code)
        SC_UP:    dir_of = 4'b0001;
        SC_DOWN:  dir_of = 4'b0010;
        SC_LEFT:  dir_of = 4'b0100;
        SC_RIGHT: dir_of = 4'b1000;
        default:  dir_of = 4'b0000;
      endcase
    end else begin
      case (code)
        SC_W:    dir_of = 4'b0001;
        SC_S:    dir_of = 4'b0010;
        SC_A:    dir_of = 4'b0100;
        SC_D:    dir_of = 4'b1000;
        default: dir_of = 4'b0000;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and key-event output bundle of the PS/2 decoder.
// master = byte source / event consumer side, slave = decoder side.
interface ps2_key_decoder_if;
  logic [7:0] rx_data;
  logic       read_data;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic [6:0] ascii_out;

  modport master (
    output rx_data, read_data,
    input  key_up, key_down, key_left, key_right,
    input  key_valid, key_code, key_ext, key_release, ascii_out
  );

  modport slave (
    input  rx_data, read_data,
    output key_up, key_down, key_left, key_right,
    output key_valid, key_code, key_ext, key_release, ascii_out
  );
endinterface

// File: rtl/ps2_ascii_map.sv
// Scan-code set 2 to uppercase ASCII lookup; only built when PS2_ASCII_EN is defined.
`ifdef PS2_ASCII_EN
module ps2_ascii_map (
  input  logic [7:0] code,
  input  logic       ext,
  output logic [6:0] ascii
);
  always_comb begin
    ascii = 7'h00;
    if (!ext) begin
      case (code)
        8'h45: ascii = 7'h30;  8'h16: ascii = 7'h31;  8'h1E: ascii = 7'h32;
        8'h26: ascii = 7'h33;  8'h25: ascii = 7'h34;  8'h2E: ascii = 7'h35;
        8'h36: ascii = 7'h36;  8'h3D: ascii = 7'h37;  8'h3E: ascii = 7'h38;
        8'h46: ascii = 7'h39;
        8'h1C: ascii = 7'h41;  8'h32: ascii = 7'h42;  8'h21: ascii = 7'h43;
        8'h23: ascii = 7'h44;  8'h24: ascii = 7'h45;  8'h2B: ascii = 7'h46;
        8'h34: ascii = 7'h47;  8'h33: ascii = 7'h48;  8'h43: ascii = 7'h49;
        8'h3B: ascii = 7'h4A;  8'h42: ascii = 7'h4B;  8'h4B: ascii = 7'h4C;
        8'h3A: ascii = 7'h4D;  8'h31: ascii = 7'h4E;  8'h44: ascii = 7'h4F;
        8'h4D: ascii = 7'h50;  8'h15: ascii = 7'h51;  8'h2D: ascii = 7'h52;
        8'h1B: ascii = 7'h53;  8'h2C: ascii = 7'h54;  8'h3C: ascii = 7'h55;
        8'h2A: ascii = 7'h56;  8'h1D: ascii = 7'h57;  8'h22: ascii = 7'h58;
        8'h35: ascii = 7'h59;  8'h1A: ascii = 7'h5A;
        8'h29: ascii = 7'h20;
        default: ascii = 7'h00;
      endcase
    end
  end
endmodule
`endif

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code parser: make/break/E0/E1 sequences into direction levels and key events.
// Define PS2_ASCII_EN to register an ASCII translation of each event's key code.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic               clk,
  input logic               reset,
  ps2_key_decoder_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       pause_cnt;
  logic [3:0]       levels;
  logic             valid_q;
  logic [7:0]       code_q;
  logic             ext_q;
  logic             rel_q;

  logic             fire;
  logic             fire_ext;
  logic             fire_rel;
  logic [3:0]       dir;
  logic [7:0]       rx;

  assign rx = bus.rx_data;

  // Decide whether the byte on this strobe completes a scan code.
  always_comb begin
    fire     = 1'b0;
    fire_ext = 1'b0;
    fire_rel = 1'b0;
    if (bus.read_data) begin
      case (state)
        ST_IDLE:    fire = !(rx inside {PFX_E0, PFX_F0, PFX_E1, CODE_FA, CODE_AA,
                                        CODE_OV0, CODE_OVF});
        ST_EXT: begin
          fire     = !(rx inside {PFX_F0, PFX_E0});
          fire_ext = 1'b1;
        end
        ST_BRK: begin
          fire     = 1'b1;
          fire_rel = 1'b1;
        end
        ST_EXT_BRK: begin
          fire     = 1'b1;
          fire_ext = 1'b1;
          fire_rel = 1'b1;
        end
        default: fire = 1'b0;
      endcase
    end
  end

  assign dir = dir_of(rx, fire_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pause_cnt <= '0;
      levels    <= '0;
      valid_q   <= 1'b0;
      code_q    <= 8'h00;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      valid_q <= fire;
      if (fire) begin
        code_q <= rx;
        ext_q  <= fire_ext;
        rel_q  <= fire_rel;
        levels <= fire_rel ? (levels & ~dir) : (levels | dir);
      end

      if (bus.read_data) begin
        // A strobe always wins over timeout expiry on the same cycle.
        cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (rx == PFX_E0)       state <= ST_EXT;
            else if (rx == PFX_F0)  state <= ST_BRK;
            else if (rx == PFX_E1) begin
              state     <= ST_PAUSE;
              pause_cnt <= PAUSE_SKIP;
            end else if (rx == CODE_OV0 || rx == CODE_OVF) begin
              levels <= '0;
            end
          end
          ST_EXT: begin
            if (rx == PFX_F0)       state <= ST_EXT_BRK;
            else if (rx != PFX_E0)  state <= ST_IDLE;
          end
          ST_BRK, ST_EXT_BRK: state <= ST_IDLE;
          ST_PAUSE: begin
            pause_cnt <= pause_cnt - 3'd1;
            if (pause_cnt == 3'd1) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign bus.key_up      = levels[0];
  assign bus.key_down    = levels[1];
  assign bus.key_left    = levels[2];
  assign bus.key_right   = levels[3];
  assign bus.key_valid   = valid_q;
  assign bus.key_code    = code_q;
  assign bus.key_ext     = ext_q;
  assign bus.key_release = rel_q;

`ifdef PS2_ASCII_EN
  logic [6:0] ascii_next;
  logic [6:0] ascii_q;

  ps2_ascii_map u_ascii_map (
    .code  (rx),
    .ext   (fire_ext),
    .ascii (ascii_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    ascii_q <= 7'h00;
    else if (fire) ascii_q <= ascii_next;
  end

  assign bus.ascii_out = ascii_q;
`else
  assign bus.ascii_out = 7'h00;
`endif

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream stage between Ps2Interface and the VGA controller's movement logic. Consumes the raw received-byte stream (rx_data plus the read_data strobe) and parses make, break, E0-extended and E1-pause sequences. Maintains held-key levels for the four directions, which replace the board buttons as the box-move inputs. Emits one key-event pulse per completed scan code for the future sprite/ASCII path.

Parameters:
TIMEOUT_CYCLES, 200000, clk cycles allowed between prefix byte and next byte before the parser abandons the sequence (2 ms at 100 MHz)
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-low reset
rx_data  input  8  byte from Ps2Interface, valid while read_data is high
read_data  input  1  one-cycle strobe: new byte present
key_up  output  1  level, high while the up arrow (E0 75) or W (1D) is held
key_down  output  1  level, high while the down arrow (E0 72) or S (1B) is held
key_left  output  1  level, high while the left arrow (E0 6B) or A (1C) is held
key_right  output  1  level, high while the right arrow (E0 74) or D (23) is held
key_valid  output  1  one-cycle pulse: completed scan code
key_code  output  8  final scan byte of the event, held until the next event
key_ext  output  1  event carried the E0 prefix
key_release  output  1  event was a break (F0 seen)
ascii_out  output  7  ASCII of key_code (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous): state IDLE, timeout counter 0, all key_* levels 0, key_valid 0, key_code 8'h00, key_ext 0, key_release 0, ascii_out 0.
- Bytes are sampled only on cycles where read_data=1. Every output is registered; there is no combinational path from rx_data.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - IDLE: E0 goes to EXT. F0 goes to BRK. E1 goes to PAUSE with the skip count set to 7. FA (ack) and AA (BAT) are ignored and the FSM stays in IDLE. 00 or FF (overflow) clears all four key levels with no event. Any other byte is a make event.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte is an extended make event, then return to IDLE.
  - BRK: any byte is a break event, then return to IDLE.
  - EXT_BRK: any byte is an extended break event, then return to IDLE.
  - PAUSE: decrement the skip count on each byte. Return to IDLE when the count reaches 0. No event and no level change.
- An event sets key_valid=1 on the cycle after the final byte's strobe (latency 1) and updates key_code, key_ext and key_release on that same cycle.
- Level update on that same cycle:
  - A make sets the mapped direction bit.
  - A break clears it.
  - An arrow and its WASD alias share one bit; releasing either one clears the bit.
  - Unmapped codes produce an event only.
- Timeout: in any state other than IDLE, the counter increments every cycle without a strobe and resets to 0 on a strobe. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE with no event and the counter resets to 0. In IDLE the counter is held at 0.
- Simultaneous events: a strobe on the expiry cycle wins. The byte is parsed in the current state and the counter resets.
- Opposing directions (up and down both high) are passed through unchanged; arbitration belongs to the consumer.
- Reset asserted mid-sequence discards the partial sequence and drops all levels.

Optional Feature:
- Macro: PS2_ASCII_EN.
- Defined: ascii_out is registered alongside key_code and is valid on the key_valid cycle.
  - Scan codes for 0-9 map to 7'h30-7'h39.
  - Scan codes for A-Z map to 7'h41-7'h5A (uppercase only).
  - Space (29) maps to 7'h20.
  - Extended codes and all other codes map to 7'h00.
- Undefined: ascii_out is tied to 7'h00 and the lookup logic is not synthesized.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state encoding;
  - prefix constants E0, E1, F0, FA, AA;
  - direction scan-code constants for the arrows and WASD;
  - the pause skip count (7).
- One sub-module, ps2_ascii_map: combinational scan-to-ASCII case table, instantiated only under PS2_ASCII_EN.

Test Plan:
- Strobe 1D, then F0 1D -> key_up=1 one cycle after the 1D strobe; key_valid pulses twice; second pulse has key_release=1 and key_code=8'h1D; key_up=0 after the second.
- Strobe E0 6B, then E0 F0 6B -> key_left rises one cycle after 6B with key_ext=1; falls after the release; 2 key_valid pulses with key_ext=1.
- Strobe E1 14 77 E1 F0 14 F0 77 -> zero key_valid pulses, levels unchanged, FSM in IDLE afterwards; then strobe 1C -> key_left=1.
- Strobe E0, then idle TIMEOUT_CYCLES cycles, then 74 -> 74 is treated as a non-extended make, key_ext=0, key_right stays 0; repeat with a strobe landing exactly on the expiry cycle -> extended make, key_right=1.
- Hold W and D, strobe FF -> key_up and key_right drop to 0, no key_valid; strobe FA and AA -> no effect.
- With PS2_ASCII_EN: strobe 1C -> ascii_out=7'h41 on the key_valid cycle; strobe 45 -> 7'h30. Without the macro -> ascii_out=0 throughout. Also assert reset mid E0 F0 -> all outputs return to reset values asynchronously.
